id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the 5-stage core. It captures the two register-file read operands, immediate, register specifiers and control bundle at the end of ID and presents them to EX one cycle later. It also contains the load-use interlock: it raises a stall to IF/ID and inserts a bubble. While held, it snoops the writeback port so held operands never go stale.

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and writeback snooping while held.
// Optional stall-cycle performance counter enabled by defining IDEX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int AWL = 5,
    parameter int DWL = 32,
    parameter int CWL = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [DWL-1:0] id_rd1,
    input  logic [DWL-1:0] id_rd2,
    input  logic [AWL-1:0] id_rs,
    input  logic [AWL-1:0] id_rt,
    input  logic [AWL-1:0] id_wa,
    input  logic [DWL-1:0] id_imm,
    input  logic [CWL-1:0] id_ctrl,
    input  logic           id_memread,
    input  logic           id_use_rt,
    input  logic           hold,
    input  logic           flush,
    input  logic           wb_we,
    input  logic [AWL-1:0] wb_wa,
    input  logic [DWL-1:0] wb_wd,
    output logic           ex_valid,
    output logic [DWL-1:0] ex_rd1,
    output logic [DWL-1:0] ex_rd2,
    output logic [DWL-1:0] ex_imm,
    output logic [AWL-1:0] ex_rs,
    output logic [AWL-1:0] ex_rt,
    output logic [AWL-1:0] ex_wa,
    output logic [CWL-1:0] ex_ctrl,
    output logic           ex_memread,
    output logic           stall,
    output logic [15:0]    stall_cnt
);

    logic lu_s;
    logic snoop_rs_s;
    logic snoop_rt_s;

    // Load-use detection and writeback snoop matches; register 0 never matches.
    always_comb begin
        lu_s       = 1'b0;
        snoop_rs_s = 1'b0;
        snoop_rt_s = 1'b0;
        if (ex_valid && ex_memread && id_valid && (ex_wa != {AWL{1'b0}})) begin
            lu_s = (ex_wa == id_rs) || (id_use_rt && (ex_wa == id_rt));
        end else begin
            lu_s = 1'b0;
        end
        if (wb_we && (wb_wa != {AWL{1'b0}})) begin
            snoop_rs_s = (wb_wa == ex_rs);
            snoop_rt_s = (wb_wa == ex_rt);
        end else begin
            snoop_rs_s = 1'b0;
            snoop_rt_s = 1'b0;
        end
    end

    assign stall = lu_s | hold;

    // Pipeline register: hold (with snoop) beats flush, flush/load-use bubble beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_rd1     <= {DWL{1'b0}};
            ex_rd2     <= {DWL{1'b0}};
            ex_imm     <= {DWL{1'b0}};
            ex_rs      <= {AWL{1'b0}};
            ex_rt      <= {AWL{1'b0}};
            ex_wa      <= {AWL{1'b0}};
            ex_ctrl    <= {CWL{1'b0}};
            ex_memread <= 1'b0;
        end else if (hold) begin
            if (snoop_rs_s) begin
                ex_rd1 <= wb_wd;
            end
            if (snoop_rt_s) begin
                ex_rd2 <= wb_wd;
            end
        end else if (flush || lu_s) begin
            ex_valid   <= 1'b0;
            ex_rd1     <= {DWL{1'b0}};
            ex_rd2     <= {DWL{1'b0}};
            ex_imm     <= {DWL{1'b0}};
            ex_rs      <= {AWL{1'b0}};
            ex_rt      <= {AWL{1'b0}};
            ex_wa      <= {AWL{1'b0}};
            ex_ctrl    <= {CWL{1'b0}};
            ex_memread <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            ex_rd1     <= id_rd1;
            ex_rd2     <= id_rd2;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wa      <= id_wa;
            ex_ctrl    <= id_ctrl;
            ex_memread <= id_memread;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of stalled edges; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, load-use,
// flush/hold priority, writeback snoop and the stall counter.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_wa;
    logic [15:0] id_ctrl;
    logic        id_memread, id_use_rt, hold, flush, wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        ex_valid;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wa;
    logic [15:0] ex_ctrl;
    logic        ex_memread, stall;
    logic [15:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    id_ex_stage #(.AWL(5), .DWL(32), .CWL(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs(id_rs), .id_rt(id_rt),
        .id_wa(id_wa), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_memread(id_memread), .id_use_rt(id_use_rt),
        .hold(hold), .flush(flush), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wa(ex_wa), .ex_ctrl(ex_ctrl),
        .ex_memread(ex_memread), .stall(stall), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_rd1 = 32'h0; id_rd2 = 32'h0; id_imm = 32'h0;
        id_rs = 5'd0; id_rt = 5'd0; id_wa = 5'd0; id_ctrl = 16'h0;
        id_memread = 1'b0; id_use_rt = 1'b0; hold = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0;
    endtask

    task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                               input logic [4:0] wa, input logic memread,
                               input logic [31:0] rd1, input logic [31:0] rd2);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rt = use_rt; id_wa = wa;
        id_memread = memread; id_rd1 = rd1; id_rd2 = rd2;
        id_imm = 32'h0000_0010; id_ctrl = 16'h00A5;
    endtask

    task automatic test_reset();
        set_idle();
        drive_instr(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 32'h1111_1111, 32'h2222_2222);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ex_valid !== 1'b0 || ex_rd1 !== 32'h0 || ex_wa !== 5'd0 || ex_ctrl !== 16'h0 || ex_memread !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%0b rd1=%h wa=%0d ctrl=%h memread=%0b, expected all 0",
                     ex_valid, ex_rd1, ex_wa, ex_ctrl, ex_memread);
        end
        tests_run++;
        if (stall !== 1'b0 || stall_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_stall: stall=%0b cnt=%h, expected 0/0", stall, stall_cnt);
        end
        hold = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_stall_hold: stall=%0b, expected 1", stall);
        end
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        set_idle();
        drive_instr(5'd4, 5'd6, 1'b1, 5'd3, 1'b0, 32'h0000_1234, 32'h0000_5678);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_stall: stall=%0b, expected 0", stall);
        end
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_rd1 !== 32'h0000_1234 || ex_rd2 !== 32'h0000_5678 ||
            ex_wa !== 5'd3 || ex_rs !== 5'd4 || ex_rt !== 5'd6 || ex_ctrl !== 16'h00A5 ||
            ex_imm !== 32'h0000_0010 || ex_memread !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_capture: valid=%0b rd1=%h rd2=%h wa=%0d rs=%0d rt=%0d ctrl=%h imm=%h, expected 1 1234 5678 3 4 6 00a5 10",
                     ex_valid, ex_rd1, ex_rd2, ex_wa, ex_rs, ex_rt, ex_ctrl, ex_imm);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        drive_instr(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h0, 32'h0);
        tick();
        drive_instr(5'd5, 5'd8, 1'b1, 5'd10, 1'b0, 32'h0000_00AA, 32'h0000_00BB);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_stall_rs: stall=%0b, expected 1", stall);
        end
        tick();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0 || ex_memread !== 1'b0 || ex_wa !== 5'd0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_bubble: valid=%0b ctrl=%h memread=%0b wa=%0d stall=%0b, expected 0 0 0 0 0",
                     ex_valid, ex_ctrl, ex_memread, ex_wa, stall);
        end
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_rd1 !== 32'h0000_00AA || ex_rs !== 5'd5 || ex_wa !== 5'd10) begin
            tests_failed++;
            $display("FAIL lu_replay: valid=%0b rd1=%h rs=%0d wa=%0d, expected 1 aa 5 10",
                     ex_valid, ex_rd1, ex_rs, ex_wa);
        end
        // RT dependence counts only when the instruction actually reads RT
        drive_instr(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h0, 32'h0);
        tick();
        drive_instr(5'd9, 5'd5, 1'b0, 5'd11, 1'b0, 32'h0, 32'h0);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_rt_unused: stall=%0b, expected 0", stall);
        end
        id_use_rt = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_rt_used: stall=%0b, expected 1", stall);
        end
        tick();
        drive_instr(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 32'h0, 32'h0);
        tick();
        drive_instr(5'd0, 5'd0, 1'b1, 5'd12, 1'b0, 32'h0, 32'h0);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_r0: stall=%0b, expected 0", stall);
        end
        tick();
    endtask

    task automatic test_flush_priority();
        set_idle();
        drive_instr(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h0, 32'h0);
        tick();
        drive_instr(5'd5, 5'd2, 1'b1, 5'd13, 1'b0, 32'h0000_0077, 32'h0);
        flush = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_lu_stall: stall=%0b, expected 1", stall);
        end
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        tests_run++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0 || ex_wa !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_lu_bubble: valid=%0b ctrl=%h wa=%0d, expected 0 0 0", ex_valid, ex_ctrl, ex_wa);
        end
        drive_instr(5'd14, 5'd15, 1'b1, 5'd16, 1'b0, 32'h0000_3333, 32'h0000_4444);
        tick();
        drive_instr(5'd17, 5'd18, 1'b1, 5'd19, 1'b1, 32'h0000_9999, 32'h0000_8888);
        hold = 1'b1;
        flush = 1'b1;
        tick();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_rd1 !== 32'h0000_3333 || ex_rd2 !== 32'h0000_4444 ||
            ex_wa !== 5'd16 || ex_rs !== 5'd14 || ex_memread !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_flush: valid=%0b rd1=%h rd2=%h wa=%0d rs=%0d memread=%0b, expected 1 3333 4444 16 14 0",
                     ex_valid, ex_rd1, ex_rd2, ex_wa, ex_rs, ex_memread);
        end
        set_idle();
    endtask

    task automatic test_hold_snoop();
        set_idle();
        drive_instr(5'd7, 5'd7, 1'b1, 5'd20, 1'b0, 32'h0000_0001, 32'h0000_0002);
        tick();
        set_idle();
        hold = 1'b1;
        wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h0000_CAFE;
        tick();
        tests_run++;
        if (ex_rd1 !== 32'h0000_CAFE || ex_rd2 !== 32'h0000_CAFE || ex_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL snoop_both: rd1=%h rd2=%h valid=%0b, expected cafe cafe 1", ex_rd1, ex_rd2, ex_valid);
        end
        wb_wa = 5'd0; wb_wd = 32'h0000_BEEF;
        tick();
        tests_run++;
        if (ex_rd1 !== 32'h0000_CAFE || ex_rd2 !== 32'h0000_CAFE) begin
            tests_failed++;
            $display("FAIL snoop_r0: rd1=%h rd2=%h, expected cafe cafe", ex_rd1, ex_rd2);
        end
        // Snoop on one operand only, and no snoop without write enable
        hold = 1'b0;
        drive_instr(5'd3, 5'd4, 1'b1, 5'd21, 1'b0, 32'h0000_0011, 32'h0000_0022);
        tick();
        set_idle();
        hold = 1'b1;
        wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h0000_D00D;
        tick();
        wb_we = 1'b0; wb_wa = 5'd3; wb_wd = 32'h0000_F00F;
        tick();
        tests_run++;
        if (ex_rd1 !== 32'h0000_0011 || ex_rd2 !== 32'h0000_D00D) begin
            tests_failed++;
            $display("FAIL snoop_rt_only: rd1=%h rd2=%h, expected 11 d00d", ex_rd1, ex_rd2);
        end
        set_idle();
    endtask

    task automatic test_counter();
        set_idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        hold = 1'b0;
        #1;
`ifdef IDEX_PERF_CNT_EN
        tests_run++;
        if (stall_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL cnt_three: cnt=%0d, expected 3", stall_cnt);
        end
        hold = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        hold = 1'b0;
        tests_run++;
        if (stall_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL cnt_saturate: cnt=%h, expected ffff", stall_cnt);
        end
`else
        tests_run++;
        if (stall_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL cnt_absent: cnt=%h, expected 0000", stall_cnt);
        end
`endif
        tick();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_normal();
        test_load_use();
        test_flush_priority();
        test_hold_snoop();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
